// File: rtl/seq_mult_16_bit_if.sv
// ---------------------------------------------------------------------------
// seq_mult_16_bit_if
//   Groups the request/response signals of the sequential 16x16 multiplier.
//
//   Handshake: the master raises start with operands a/b stable at the
//   rising clock edge; the request is taken only while the multiplier is
//   idle (busy=0), and requests made while busy=1 are dropped, not queued.
//   Once taken, a/b may change freely. done is a one-cycle pulse, and
//   product is valid in that cycle. product then holds until the next
//   multiply completes.
//
//   Signals:
//     start    master -> slave  1   request a multiply
//     a        master -> slave  16  multiplicand
//     b        master -> slave  16  multiplier
//     product  slave -> master  32  a*b
//     busy     slave -> master  1   multiply in progress (RUN or DONE)
//     done     slave -> master  1   one-cycle completion pulse
// ---------------------------------------------------------------------------
interface seq_mult_16_bit_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] product;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output a,
        output b,
        input  product,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output product,
        output busy,
        output done
    );
endinterface

// File: rtl/seq_mult_16_bit.sv
// ---------------------------------------------------------------------------
// seq_mult_16_bit
//   Unsigned 16x16 -> 32-bit shift-and-add multiplier. The datapath performs
//   one partial-product add and one right shift per clock. Each add goes
//   through a 16-bit ripple-of-CLA adder whose carry-in is tied to 0.
//
//   Ports:
//     clk          in   1   rising-edge clock
//     rst_n        in   1   asynchronous active-low reset
//     bus          slave modport of seq_mult_16_bit_if (start/a/b in,
//                  product/busy/done out)
//     dbg_state_o  out  2   current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
//   Timing: a start taken at edge E0 is followed by 16 RUN edges, E1..E16.
//   done is high for the cycle after E16, and busy is high from E0 to E17.
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead block.
module seq_mult_cla4 (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = x_i & y_i;
        p    = x_i ^ y_i;
        c[0] = c_i;
        c[1] = g[0] | (p[0] & c_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_i);
        s_o  = p ^ c[3:0];
        c_o  = c[4];
    end
endmodule

// 16-bit adder: four CLA blocks with the carry rippled between them.
module seq_mult_cla16 (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);
    logic [4:0] carry;

    assign carry[0] = c_i;

    for (genvar n = 0; n < 4; n++) begin : g_blk
        seq_mult_cla4 u_cla4 (
            .x_i (x_i[4*n +: 4]),
            .y_i (y_i[4*n +: 4]),
            .c_i (carry[n]),
            .s_o (s_o[4*n +: 4]),
            .c_o (carry[n+1])
        );
    end

    assign c_o = carry[4];
endmodule

module seq_mult_16_bit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_mult_16_bit_if.slave        bus,
    output logic [1:0]              dbg_state_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        mcand_q, mcand_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        product_q, product_d;

    // Partial-product add: hi + (lsb ? mcand : 0).
    logic [15:0]        addend;
    logic [15:0]        sum;
    logic               sum_c;

    assign addend = acc_q[0] ? mcand_q : 16'h0000;

    seq_mult_cla16 u_adder (
        .x_i (acc_q[31:16]),
        .y_i (addend),
        .c_i (1'b0),
        .s_o (sum),
        .c_o (sum_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    acc_d   = {16'h0000, bus.b};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // This is a 33-bit shift of {carry, sum, lo}, so the adder
                // carry lands in acc[31] and is never lost.
                acc_d = {sum_c, sum, acc_q[15:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    product_d = {sum_c, sum, acc_q[15:1]};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // These outputs are decoded from registered state only, so they change
    // exactly at clock edges (or at reset).
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.product  = product_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_seq_mult_16_bit.sv
module tb_seq_mult_16_bit;
    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;
    int          checks;
    int          errors;
    logic [31:0] last_prod;

    seq_mult_16_bit_if bus ();

    seq_mult_16_bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain unsigned multiplication.
    function automatic logic [31:0] ref_mult(input logic [15:0] x, input logic [15:0] y);
        return {16'h0000, x} * {16'h0000, y};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Driver: one multiply. The operands change to a2/b2 right after the
    // start is taken. The task checks latency, busy, product hold and result.
    task automatic run_mult(input logic [15:0] ta, input logic [15:0] tb,
                            input logic [15:0] ta2, input logic [15:0] tb2,
                            input string tag);
        logic [31:0] exp;
        int          lat;
        logic        busy_ok;
        exp     = ref_mult(ta, tb);
        lat     = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        @(negedge clk);                    // after E0
        bus.start = 1'b0;
        bus.a     = ta2;
        bus.b     = tb2;
        check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
        check({tag, "_prod_hold"}, bus.product, last_prod);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);                // after E_i
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(lat), 32'd16);
        check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
        check({tag, "_product"}, bus.product, exp);
        @(negedge clk);                    // after E17
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        last_prod = exp;
    endtask

    initial begin
        int          n_done;
        int          first_done;
        int          prev_done;
        logic        gap_ok;
        logic        stable_ok;
        logic [15:0] ra, rb;

        checks    = 0;
        errors    = 0;
        last_prod = 32'd0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 16'h0;
        bus.b     = 16'h0;

        // Reset state
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_product", bus.product, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed multiplies
        run_mult(16'd34783, 16'd3443, 16'd34783, 16'd3443, "t1");
        check("t1_value", last_prod, 32'd119757869);
        run_mult(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, "t2_max");
        check("t2_value", last_prod, 32'hFFFE_0001);
        run_mult(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, "t2_zero_a");
        run_mult(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, "t2_zero_b");

        // A second request during RUN and during DONE is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd5; bus.b = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd9; bus.b = 16'd9;
        @(negedge clk);
        bus.start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                check("t3_product", bus.product, 32'd35);
                bus.start = 1'b1;
                break;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("t3_done_count", 32'(n_done), 32'd1);
        check("t3_idle_after", 32'(bus.busy), 32'd0);
        check("t3_product_hold", bus.product, 32'd35);
        last_prod = 32'd35;

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd1234; bus.b = 16'd4321;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_busy", 32'(bus.busy), 32'd0);
        check("t4_rst_done", 32'(bus.done), 32'd0);
        check("t4_rst_product", bus.product, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        last_prod = 32'd0;
        run_mult(16'd3, 16'd4, 16'd3, 16'd4, "t4_after");

        // Back-to-back operation with start held high
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd58783; bus.b = 16'd33;
        n_done     = 0;
        first_done = -1;
        prev_done  = -1;
        gap_ok     = 1'b1;
        stable_ok  = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (first_done < 0) first_done = i;
                else if (i - prev_done != 18) gap_ok = 1'b0;
                prev_done = i;
                check("t5_product", bus.product, 32'd1939839);
            end else if (first_done < 0) begin
                if (bus.product !== 32'd12) stable_ok = 1'b0;
            end else if (bus.product !== 32'd1939839) begin
                stable_ok = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("t5_first_done", 32'(first_done), 32'd17);
        check("t5_done_count", 32'(n_done), 32'd3);
        check("t5_period", 32'(gap_ok), 32'd1);
        check("t5_stable", 32'(stable_ok), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("t5_drain", 32'(bus.busy), 32'd0);
        last_prod = 32'd1939839;

        // Operands change right after the start is taken
        run_mult(16'd457, 16'd45887, 16'hA5A5, 16'h5A5A, "t6");
        check("t6_value", last_prod, 32'd20970359);

        // Random operands, with idle gaps in which product must hold
        for (int k = 0; k < 10; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_mult(ra, rb, 16'($urandom), 16'($urandom), "rand");
            repeat ($urandom_range(0, 4)) @(negedge clk);
            check("rand_idle_hold", bus.product, last_prod);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
